// File: rtl/user_obi_mgr.sv
// Single-outstanding OBI manager bridging a valid/ready command/response
// pair onto the croc manager OBI port, with an rvalid timeout in the response phase.

package croc_pkg;

  localparam int unsigned MgrIdWidth = 1;
  typedef logic [MgrIdWidth-1:0] mgr_id_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    mgr_id_t     aid;
    logic        a_optional;
  } mgr_obi_a_chan_t;

  typedef struct packed {
    mgr_obi_a_chan_t a;
    logic            req;
  } mgr_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    mgr_id_t     rid;
    logic        err;
    logic        r_optional;
  } mgr_obi_r_chan_t;

  typedef struct packed {
    mgr_obi_r_chan_t r;
    logic            gnt;
    logic            rvalid;
  } mgr_obi_rsp_t;

endpackage

module user_obi_mgr
  import croc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned AID            = 0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cmd_valid_i,
  output logic         cmd_ready_o,
  input  logic         cmd_we_i,
  input  logic [31:0]  cmd_addr_i,
  input  logic [31:0]  cmd_wdata_i,
  input  logic [3:0]   cmd_be_i,
  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output logic [31:0]  rsp_rdata_o,
  output logic         rsp_err_o,
  output logic         rsp_timeout_o,
  output logic         busy_o,
  output mgr_obi_req_t obi_req_o,
  input  mgr_obi_rsp_t obi_rsp_i
);

  localparam bit          TimeoutEn = (TIMEOUT_CYCLES != 0);
  localparam int unsigned CntW      = TimeoutEn ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntLast = TimeoutEn ? CntW'(TIMEOUT_CYCLES - 1) : '0;
  localparam mgr_id_t     AidL      = mgr_id_t'(AID);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP,
    DONE
  } state_e;

  state_e          r_state;
  state_e          w_state_nxt;
  mgr_obi_req_t    r_req;
  logic [CntW-1:0] r_cnt;
  logic            r_stale;
  logic [31:0]     r_rdata;
  logic            r_err;
  logic            r_timeout;

  logic w_accept;
  logic w_timeout_hit;
  logic w_unused;

  assign cmd_ready_o   = (r_state == IDLE) && !r_stale;
  assign w_accept      = cmd_valid_i && cmd_ready_o;
  assign w_timeout_hit = TimeoutEn && (r_cnt == CntLast);
  assign w_unused      = obi_rsp_i.r.r_optional;

  assign obi_req_o     = r_req;
  assign rsp_valid_o   = (r_state == DONE);
  assign rsp_rdata_o   = r_rdata;
  assign rsp_err_o     = r_err;
  assign rsp_timeout_o = r_timeout;
  assign busy_o        = (r_state != IDLE) || r_stale;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept)                          w_state_nxt = REQ;
      REQ:  if (obi_rsp_i.gnt)                     w_state_nxt = RSP;
      RSP:  if (obi_rsp_i.rvalid || w_timeout_hit) w_state_nxt = DONE;
      DONE: if (rsp_ready_i)                       w_state_nxt = IDLE;
      default:                                     w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_req     <= '0;
      r_cnt     <= '0;
      r_stale   <= 1'b0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      // A late rvalid from a timed-out transaction is swallowed here.
      if (r_state != RSP && obi_rsp_i.rvalid) r_stale <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_req.req          <= 1'b1;
            r_req.a.addr       <= cmd_addr_i;
            r_req.a.we         <= cmd_we_i;
            r_req.a.be         <= cmd_be_i;
            r_req.a.wdata      <= cmd_wdata_i;
            r_req.a.aid        <= AidL;
            r_req.a.a_optional <= 1'b0;
          end
        end
        REQ: begin
          if (obi_rsp_i.gnt) begin
            r_req.req <= 1'b0;
            r_cnt     <= '0;
          end
        end
        RSP: begin
          // rvalid takes priority over a timeout firing in the same cycle.
          if (obi_rsp_i.rvalid) begin
            r_rdata   <= r_req.a.we ? '0 : obi_rsp_i.r.rdata;
            r_err     <= obi_rsp_i.r.err || (obi_rsp_i.r.rid != AidL);
            r_timeout <= 1'b0;
          end else if (w_timeout_hit) begin
            r_rdata   <= '0;
            r_err     <= 1'b1;
            r_timeout <= 1'b1;
            r_stale   <= 1'b1;
          end else if (TimeoutEn) begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_user_obi_mgr.sv
// Directed and randomized transactions against a transaction-level model of
// the OBI manager: expected request, latency, response and stale behaviour.

module tb_user_obi_mgr;
  import croc_pkg::*;

  localparam int unsigned TO  = 8;
  localparam int unsigned AID = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_we;
  logic [31:0]  cmd_addr;
  logic [31:0]  cmd_wdata;
  logic [3:0]   cmd_be;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [31:0]  rsp_rdata;
  logic         rsp_err;
  logic         rsp_timeout;
  logic         busy;
  mgr_obi_req_t obi_req;
  mgr_obi_rsp_t obi_rsp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  user_obi_mgr #(
    .TIMEOUT_CYCLES(TO),
    .AID           (AID)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_we_i     (cmd_we),
    .cmd_addr_i   (cmd_addr),
    .cmd_wdata_i  (cmd_wdata),
    .cmd_be_i     (cmd_be),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_err_o    (rsp_err),
    .rsp_timeout_o(rsp_timeout),
    .busy_o       (busy),
    .obi_req_o    (obi_req),
    .obi_rsp_i    (obi_rsp)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic mgr_obi_req_t exp_req(input logic we, input logic [31:0] addr,
                                           input logic [31:0] wdata, input logic [3:0] be);
    mgr_obi_req_t e;
    e              = '0;
    e.req          = 1'b1;
    e.a.addr       = addr;
    e.a.we         = we;
    e.a.be         = be;
    e.a.wdata      = wdata;
    e.a.aid        = mgr_id_t'(AID);
    e.a.a_optional = 1'b0;
    return e;
  endfunction

  task automatic check_done(input logic [31:0] erd, input logic eerr, input logic eto);
    check("done_valid", rsp_valid, 1'b1);
    check("done_rdata", rsp_rdata, erd);
    check("done_err", rsp_err, eerr);
    check("done_timeout", rsp_timeout, eto);
    check("done_cmd_ready", cmd_ready, 1'b0);
  endtask

  // One full transaction. rv_dly is the RSP-cycle index at which rvalid is
  // offered; values >= TO mean the responder stays silent until after timeout.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int gnt_dly, input int rv_dly,
                         input logic [31:0] rdata, input logic rerr, input logic rid,
                         input int rsp_wait, input int stale_gap, input bit noise);
    mgr_obi_req_t e;
    logic         to;
    logic [31:0]  erd;
    logic         eerr;
    e    = exp_req(we, addr, wdata, be);
    to   = (rv_dly >= int'(TO));
    erd  = (to || we) ? 32'h0 : rdata;
    eerr = to || rerr || (rid != mgr_id_t'(AID));

    check("idle_cmd_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_be = be;
    tick();
    cmd_valid = 1'b0; cmd_we = ~we; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_be = 4'($urandom);

    for (int i = 0; i <= gnt_dly; i++) begin
      obi_rsp.gnt = (i == gnt_dly);
      if (noise) begin
        rsp_ready          = 1'($urandom_range(0, 1));
        obi_rsp.rvalid     = ($urandom_range(0, 3) == 0);
        obi_rsp.r.rdata    = $urandom;
      end
      check("req_chan", obi_req, e);
      check("req_rsp_valid", rsp_valid, 1'b0);
      check("req_busy", busy, 1'b1);
      tick();
    end
    obi_rsp.gnt = 1'b0;
    obi_rsp.rvalid = 1'b0;

    for (int k = 0; k < int'(TO); k++) begin
      check("rsp_req_low", obi_req.req, 1'b0);
      check("rsp_rsp_valid", rsp_valid, 1'b0);
      check("rsp_busy", busy, 1'b1);
      if (noise) rsp_ready = 1'($urandom_range(0, 1));
      if (k == rv_dly) begin
        obi_rsp.rvalid  = 1'b1;
        obi_rsp.r.rdata = rdata;
        obi_rsp.r.err   = rerr;
        obi_rsp.r.rid   = rid;
        tick();
        break;
      end
      tick();
    end
    obi_rsp.rvalid = 1'b0;
    obi_rsp.r.err  = 1'b0;
    rsp_ready      = 1'b0;

    for (int w = 0; w < rsp_wait; w++) begin
      check_done(erd, eerr, to);
      tick();
    end
    rsp_ready = 1'b1;
    check_done(erd, eerr, to);
    tick();
    rsp_ready = 1'b0;
    check("after_hs_valid", rsp_valid, 1'b0);

    if (to) begin
      for (int g = 0; g < stale_gap; g++) begin
        check("stale_cmd_ready", cmd_ready, 1'b0);
        check("stale_busy", busy, 1'b1);
        tick();
      end
      check("stale_cmd_ready", cmd_ready, 1'b0);
      obi_rsp.rvalid  = 1'b1;
      obi_rsp.r.rdata = $urandom;
      tick();
      obi_rsp.rvalid = 1'b0;
    end
    check("end_cmd_ready", cmd_ready, 1'b1);
    check("end_busy", busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_be = '0;
    rsp_ready = 1'b0;
    obi_rsp   = '0;
    tick();
    tick();
    check("rst_req", obi_req, 0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    check("rst_rdata", rsp_rdata, 0);
    check("rst_err", {rsp_err, rsp_timeout}, 2'b00);
    check("rst_cmd_ready", cmd_ready, 1'b1);

    // Zero-wait write: req in cycle 1, rsp_valid in cycle 3.
    run_txn(1'b1, 32'h2000_0000, 32'h5, 4'hF, 0, 0, 32'hFFFF_FFFF, 1'b0, 1'b1, 0, 0, 1'b0);
    // Read with grant held off 4 cycles.
    run_txn(1'b0, 32'h1000_0040, 32'h0, 4'hF, 4, 1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1, 0, 1'b0);
    // Bus error, then ID mismatch.
    run_txn(1'b0, 32'h1000_0080, 32'h0, 4'h3, 1, 2, 32'h1234_5678, 1'b1, 1'b1, 0, 0, 1'b0);
    run_txn(1'b0, 32'h1000_0084, 32'h0, 4'hC, 0, 0, 32'h8765_4321, 1'b0, 1'b0, 0, 0, 1'b0);
    // Timeout with a late rvalid afterwards.
    run_txn(1'b0, 32'h3000_0000, 32'h0, 4'hF, 0, 100, 32'h0, 1'b0, 1'b1, 0, 3, 1'b0);
    // rvalid on the last RSP cycle beats the timeout.
    run_txn(1'b0, 32'h3000_0004, 32'h0, 4'hF, 2, int'(TO) - 1, 32'hCAFE_F00D, 1'b0, 1'b1, 0, 0, 1'b0);
    // Response back-pressure for 10 cycles.
    run_txn(1'b0, 32'h4000_0000, 32'h0, 4'hF, 0, 3, 32'hA5A5_5A5A, 1'b0, 1'b1, 10, 0, 1'b0);

    // Reset while in RSP abandons the transaction.
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h5000_0000; cmd_be = 4'hF;
    tick();
    cmd_valid = 1'b0;
    obi_rsp.gnt = 1'b1;
    tick();
    obi_rsp.gnt = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_req", obi_req, 0);
    check("midrst_rsp", {rsp_valid, rsp_err, rsp_timeout}, 3'b000);
    check("midrst_rdata", rsp_rdata, 0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_cmd_ready", cmd_ready, 1'b1);
    tick();
    check("midrst_no_rsp", rsp_valid, 1'b0);
    run_txn(1'b0, 32'h5000_0004, 32'h0, 4'hF, 1, 1, 32'h0BAD_F00D, 1'b0, 1'b1, 0, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic rid;
      rid = ($urandom_range(0, 7) == 0) ? ~mgr_id_t'(AID) : mgr_id_t'(AID);
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
              $urandom_range(0, 4), $urandom_range(0, 10), $urandom,
              ($urandom_range(0, 7) == 0), rid, $urandom_range(0, 3),
              $urandom_range(0, 3), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/user_obi_mgr.md
USER_OBI_MGR -- requirements
Module: user_obi_mgr

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max cycles to wait for rvalid after gnt; 0 disables the timeout.
REQ-002 Parameter AID, default 0, transaction ID driven on obi_req_o.a.aid and expected on obi_rsp_i.r.rid.
REQ-003 clk_i  input  1  single clock; all logic on rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 cmd_valid_i  input  1  command request from user logic.
REQ-006 cmd_ready_o  output  1  command accepted when cmd_valid_i && cmd_ready_o.
REQ-007 cmd_we_i  input  1  1 = write, 0 = read.
REQ-008 cmd_addr_i  input  32  byte address.
REQ-009 cmd_wdata_i  input  32  write data.
REQ-010 cmd_be_i  input  4  byte enables.
REQ-011 rsp_valid_o  output  1  response available.
REQ-012 rsp_ready_i  input  1  response consumed when rsp_valid_o && rsp_ready_i.
REQ-013 rsp_rdata_o  output  32  read data; 0 for writes and timeouts.
REQ-014 rsp_err_o  output  1  bus error, ID mismatch, or timeout.
REQ-015 rsp_timeout_o  output  1  transaction ended by timeout.
REQ-016 busy_o  output  1  high whenever state != IDLE or a stale response is outstanding.
REQ-017 obi_req_o  output  mgr_obi_req_t  OBI manager request (croc_pkg, MgrObiCfg).
REQ-018 obi_rsp_i  input  mgr_obi_rsp_t  OBI manager response.

Function
REQ-019 FSM states IDLE, REQ, RSP, DONE; one outstanding transaction max.
REQ-020 cmd_ready_o = (state == IDLE) && !stale_q, combinational.
REQ-021 IDLE: on accept, register we/addr/wdata/be and go to REQ; obi_req_o.req high from the next cycle.
REQ-022 All obi_req_o fields are registered; a.aid = AID, a.a_optional = 0, unused fields 0.
REQ-023 REQ: req stays high and a-channel stays stable until gnt; no timeout in REQ (OBI forbids retracting req).
REQ-024 REQ with gnt: req drops next cycle, go to RSP, timeout counter cleared.
REQ-025 RSP with rvalid: capture rdata (forced to 0 if write), err = r.err || (r.rid != AID), timeout = 0, go to DONE.
REQ-026 RSP without rvalid: increment counter; when counter == TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES != 0), go to DONE with err = 1, timeout = 1, rdata = 0, set stale_q.
REQ-027 rvalid in the same cycle the timeout fires: rvalid wins; normal response, stale_q not set.
REQ-028 DONE: rsp_valid_o high, response fields stable until rsp_ready_i; on handshake go to IDLE.
REQ-029 rsp_ready_i while not in DONE is ignored.
REQ-030 stale_q clears on the first rvalid seen outside RSP; that rvalid is discarded; no command is accepted while stale_q is set.
REQ-031 rvalid outside RSP with stale_q clear is ignored.
REQ-032 Minimum latency with zero-wait responder: accept in cycle 0, req+gnt in cycle 1, rvalid in cycle 2, rsp_valid_o in cycle 3.
REQ-033 Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1 bit; it does not wrap before the timeout compare.

Reset
REQ-034 rst_i sampled high forces state IDLE, stale_q 0, counter 0, obi_req_o all zero (req 0), rsp_valid_o 0, rsp_rdata_o 0, rsp_err_o 0, rsp_timeout_o 0.
REQ-035 Reset mid-transaction abandons it; req deasserts the cycle after reset is sampled; no response is produced.

Verification
REQ-036 Write addr 0x2000_0000, wdata 0x5, be 0xF, zero-wait responder -> req in cycle 1 with those fields; rsp_valid_o in cycle 3, err 0, rdata 0.
REQ-037 Read with gnt delayed 4 cycles, rvalid rdata 0xDEAD_BEEF -> req and a-channel stable for 5 cycles; rsp_rdata_o 0xDEAD_BEEF, err 0.
REQ-038 Responder returns r.err = 1 or rid != AID -> rsp_err_o 1, rsp_timeout_o 0.
REQ-039 TIMEOUT_CYCLES = 8, rvalid withheld -> DONE after 8 RSP cycles, err 1, timeout 1; cmd_ready_o 0 until a late rvalid arrives, then 1 the next cycle.
REQ-040 rsp_ready_i held low 10 cycles in DONE -> rsp_valid_o and fields stable; cmd_ready_o 0 throughout.
REQ-041 rst_i pulsed while in RSP -> outputs return to reset values; the next command completes normally.
